heap_copy_engine: RTL

//  Responder side of the allocator copy interface (src_addr/dst_addr/copy_len/copy_active/copy_done).

---
 rtl/heap_copy_engine_pkg.sv | 6 +
 rtl/heap_copy_engine_if.sv | 18 +
 rtl/heap_copy_engine_copy_word_fifo.sv | 43 ++++
 rtl/heap_copy_engine.sv | 74 +++++++
 4 files changed

// File: rtl/heap_copy_engine_pkg.sv
// heap_copy_engine_pkg: shared heap constants and copy FSM state encodings
package heap_copy_engine_pkg;
  localparam int ADDR_W = 32;
  localparam int WORD_BYTES = 4;
  typedef enum logic [2:0] {IDLE, RD_REQ, WR_REQ, DONE, WAIT_LOW} state_e;
endpackage

// File: rtl/heap_copy_engine_if.sv
// heap_copy_engine_if: allocator copy request plus heap memory master port
interface heap_copy_engine_if;
  import heap_copy_engine_pkg::*;
  logic copy_active;
  logic [ADDR_W-1:0] src_addr, dst_addr, copy_len;
  logic copy_done, busy;
  logic mem_req, mem_we, mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  modport master (
    input copy_active, src_addr, dst_addr, copy_len, mem_ack, mem_rdata,
    output copy_done, busy, mem_req, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    output copy_active, src_addr, dst_addr, copy_len, mem_ack, mem_rdata,
    input copy_done, busy, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/heap_copy_engine_copy_word_fifo.sv
// copy_word_fifo: register FIFO holding one read burst until it is written back
module copy_word_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = din;
    wr_d = clr ? '0 : wr_q + AW'(push);
    rd_d = clr ? '0 : rd_q + AW'(pop);
    cnt_d = clr ? '0 : cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  assign dout = mem_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/heap_copy_engine.sv
// heap_copy_engine: realloc block mover, reads a burst of source words then writes them out
module heap_copy_engine
  import heap_copy_engine_pkg::*;
#(
  parameter int BURST_WORDS = 8
) (
  input logic clk,
  input logic rst,
  heap_copy_engine_if.master bus
);
  localparam int CNT_W = $clog2(BURST_WORDS) + 1;
  state_e state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [ADDR_W-3:0] left_q, left_d;
  logic push, pop, clr;
  logic [CNT_W-1:0] cnt;
  logic [31:0] head;
  copy_word_fifo #(.DEPTH(BURST_WORDS), .W(32)) u_fifo (
    .clk(clk), .rst(rst), .clr(clr), .push(push), .pop(pop),
    .din(bus.mem_rdata), .dout(head), .count(cnt)
  );
  always_comb begin
    state_d = state_q;
    src_d = src_q;
    dst_d = dst_q;
    left_d = left_q;
    push = 1'b0;
    pop = 1'b0;
    clr = 1'b0;
    case (state_q)
      IDLE: if (bus.copy_active) begin
        src_d = bus.src_addr & ~ADDR_W'(WORD_BYTES - 1);
        dst_d = bus.dst_addr & ~ADDR_W'(WORD_BYTES - 1);
        left_d = (ADDR_W-2)'(bus.copy_len >> 2);
        clr = 1'b1;
        state_d = (left_d == '0) ? DONE : RD_REQ;
      end
      RD_REQ: if (bus.mem_ack) begin
        push = 1'b1;
        src_d = src_q + ADDR_W'(WORD_BYTES);
        left_d = left_q - 1'b1;
        // burst closes when the buffer fills or the last source word arrives
        if (cnt == CNT_W'(BURST_WORDS - 1) || left_q == (ADDR_W-2)'(1)) state_d = WR_REQ;
      end
      WR_REQ: if (bus.mem_ack) begin
        pop = 1'b1;
        dst_d = dst_q + ADDR_W'(WORD_BYTES);
        if (cnt == CNT_W'(1)) state_d = (left_q != '0) ? RD_REQ : DONE;
      end
      DONE: state_d = WAIT_LOW;
      WAIT_LOW: if (!bus.copy_active) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      src_q <= '0;
      dst_q <= '0;
      left_q <= '0;
    end else begin
      state_q <= state_d;
      src_q <= src_d;
      dst_q <= dst_d;
      left_q <= left_d;
    end
  end
  assign bus.mem_req = (state_q == RD_REQ) || (state_q == WR_REQ);
  assign bus.mem_we = (state_q == WR_REQ);
  assign bus.mem_addr = (state_q == RD_REQ) ? src_q : (state_q == WR_REQ) ? dst_q : '0;
  assign bus.mem_wdata = (state_q == WR_REQ) ? head : '0;
  assign bus.copy_done = (state_q == DONE);
  assign bus.busy = (state_q != IDLE);
endmodule
